// File: rtl/chkmon_pkg.sv
// +----------------------------------------------------------------------------+
// | chkmon_pkg                                                                 |
// | Shared state encoding, failure codes and helpers for checkpoint_monitor.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package chkmon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_RUN        = 3'd2,
        ST_PASS       = 3'd3,
        ST_FAIL       = 3'd4
    } state_t;

    localparam logic [2:0] FAIL_NONE  = 3'd0;
    localparam logic [2:0] FAIL_VALUE = 3'd1;
    localparam logic [2:0] FAIL_SEQ   = 3'd2;
    localparam logic [2:0] FAIL_TMO   = 3'd3;
    localparam logic [2:0] FAIL_EARLY = 3'd4;

    // Index width that never collapses to zero bits for a one-entry table.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/chkmon_filter.sv
// +----------------------------------------------------------------------------+
// | chkmon_filter                                                              |
// | Optional 2-flop synchronizer (CHKMON_SYNC_EN) plus marker stability        |
// | filter; emits a one-cycle accept strobe with the code and its value.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module chkmon_filter
    import chkmon_pkg::*;
#(
    parameter int CHK_W      = 16,
    parameter int VAL_W      = 8,
    parameter int STABLE_CYC = 2
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             clear_i,
    input  logic [CHK_W-1:0] checkbits_i,
    input  logic [VAL_W-1:0] value_i,
    output logic             acc_o,
    output logic [CHK_W-1:0] code_o,
    output logic [VAL_W-1:0] value_o
);

    localparam int RUN_W = $clog2(STABLE_CYC + 1);

    logic [CHK_W-1:0] code_s;
    logic [VAL_W-1:0] val_s;

`ifdef CHKMON_SYNC_EN
    logic [CHK_W-1:0] code_m_q, code_s_q;
    logic [VAL_W-1:0] val_m_q, val_s_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            code_m_q <= '0;
            code_s_q <= '0;
            val_m_q  <= '0;
            val_s_q  <= '0;
        end else begin
            code_m_q <= checkbits_i;
            code_s_q <= code_m_q;
            val_m_q  <= value_i;
            val_s_q  <= val_m_q;
        end
    end

    assign code_s = code_s_q;
    assign val_s  = val_s_q;
`else
    assign code_s = checkbits_i;
    assign val_s  = value_i;
`endif

    logic [CHK_W-1:0] last_q, acc_code_q;
    logic [VAL_W-1:0] val_q;
    logic [RUN_W-1:0] run_q, run_d;
    logic             has_acc_q, acc_q, acc_d;

    // Run length saturates at STABLE_CYC; the last accepted code is remembered
    // so a long hold (or a return after a short glitch) is not accepted twice.
    always_comb begin
        run_d = RUN_W'(1);
        if (run_q != '0 && code_s == last_q) begin
            run_d = (run_q == RUN_W'(STABLE_CYC)) ? run_q : RUN_W'(run_q + 1'b1);
        end
        acc_d = (run_d == RUN_W'(STABLE_CYC)) && !(has_acc_q && code_s == acc_code_q);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            last_q     <= '0;
            run_q      <= '0;
            has_acc_q  <= 1'b0;
            acc_q      <= 1'b0;
            acc_code_q <= '0;
            val_q      <= '0;
        end else begin
            last_q <= code_s;
            run_q  <= run_d;
            acc_q  <= acc_d && !clear_i;
            if (clear_i) begin
                has_acc_q <= 1'b0;
            end else if (acc_d) begin
                has_acc_q  <= 1'b1;
                acc_code_q <= code_s;
                val_q      <= val_s;
            end
        end
    end

    assign acc_o   = acc_q;
    assign code_o  = acc_code_q;
    assign value_o = val_q;

endmodule

`default_nettype wire

// File: rtl/checkpoint_monitor.sv
// +----------------------------------------------------------------------------+
// | checkpoint_monitor                                                         |
// | Walks an ordered marker-code sequence, checks captured values against a   |
// | masked expected table, reports sticky pass/fail with per-step timeout.     |
// | Build option: CHKMON_SYNC_EN adds a 2-flop input synchronizer.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module checkpoint_monitor
    import chkmon_pkg::*;
#(
    parameter int               CHK_W      = 16,
    parameter int               VAL_W      = 8,
    parameter int               N_CHK      = 16,
    parameter logic [CHK_W-1:0] START_CODE = 16'hA040,
    parameter logic [CHK_W-1:0] PASS_CODE  = 16'hA090,
    parameter int               STABLE_CYC = 2,
    parameter int               TMO_W      = 20
) (
    input  logic                             clock,
    input  logic                             resetb,
    input  logic                             enable,
    input  logic [CHK_W-1:0]                 checkbits,
    input  logic [VAL_W-1:0]                 value,
    input  logic [$clog2(N_CHK+1)-1:0]       n_expect,
    input  logic [TMO_W-1:0]                 tmo_limit,
    input  logic                             exp_wr,
    input  logic [clog2_min1(N_CHK)-1:0]     exp_addr,
    input  logic [VAL_W-1:0]                 exp_data,
    input  logic [VAL_W-1:0]                 exp_mask,
    output logic                             busy,
    output logic                             pass,
    output logic                             fail,
    output logic [2:0]                       fail_code,
    output logic [clog2_min1(N_CHK)-1:0]     fail_index,
    output logic [VAL_W-1:0]                 fail_value
);

    localparam int NE_W  = $clog2(N_CHK + 1);
    localparam int IDX_W = clog2_min1(N_CHK);

    state_t           state_q;
    logic [NE_W-1:0]  idx_q;
    logic [TMO_W-1:0] timer_q;
    logic             busy_q, pass_q, fail_q;
    logic [2:0]       fail_code_q;
    logic [IDX_W-1:0] fail_index_q;
    logic [VAL_W-1:0] fail_value_q;

    logic             acc;
    logic [CHK_W-1:0] acc_code;
    logic [VAL_W-1:0] acc_val;

    chkmon_filter #(
        .CHK_W      (CHK_W),
        .VAL_W      (VAL_W),
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .clock       (clock),
        .resetb      (resetb),
        .clear_i     (state_q == ST_IDLE),
        .checkbits_i (checkbits),
        .value_i     (value),
        .acc_o       (acc),
        .code_o      (acc_code),
        .value_o     (acc_val)
    );

    logic [VAL_W-1:0] exp_data_q [N_CHK];
    logic [VAL_W-1:0] exp_mask_q [N_CHK];

    always_ff @(posedge clock) begin
        if (exp_wr && state_q == ST_IDLE && 32'(exp_addr) < N_CHK) begin
            exp_data_q[exp_addr] <= exp_data;
            exp_mask_q[exp_addr] <= exp_mask;
        end
    end

    logic [NE_W-1:0]  n_eff;
    logic [IDX_W-1:0] idx_rd;
    logic [CHK_W-1:0] exp_code;
    logic             miss, tmo_hit;
    logic             step_ok_d, run_pass_d;
    logic [2:0]       verdict_d;

    assign n_eff    = (n_expect > NE_W'(N_CHK)) ? NE_W'(N_CHK) : n_expect;
    assign idx_rd   = idx_q[IDX_W-1:0];
    assign exp_code = START_CODE + CHK_W'(1) + CHK_W'(idx_q);
    assign miss     = |((acc_val ^ exp_data_q[idx_rd]) & exp_mask_q[idx_rd]);
    assign tmo_hit  = (tmo_limit != '0) && (TMO_W'(timer_q + 1'b1) == tmo_limit);

    // Outcome of one RUN cycle; an acceptance always takes priority over expiry.
    always_comb begin
        step_ok_d  = 1'b0;
        run_pass_d = 1'b0;
        verdict_d  = FAIL_NONE;
        if (acc) begin
            if (acc_code == exp_code && idx_q < n_eff) begin
                if (miss) verdict_d = FAIL_VALUE;
                else      step_ok_d = 1'b1;
            end else if (acc_code == PASS_CODE) begin
                if (idx_q == n_eff) run_pass_d = 1'b1;
                else                verdict_d  = FAIL_EARLY;
            end else begin
                verdict_d = FAIL_SEQ;
            end
        end else if (tmo_hit) begin
            verdict_d = FAIL_TMO;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb || !enable) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            timer_q      <= '0;
            busy_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_code_q  <= FAIL_NONE;
            fail_index_q <= '0;
            fail_value_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_WAIT_START;
                    busy_q  <= 1'b1;
                    idx_q   <= '0;
                    timer_q <= '0;
                end
                ST_WAIT_START: begin
                    if (acc && acc_code == START_CODE) begin
                        state_q <= ST_RUN;
                        idx_q   <= '0;
                        timer_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (run_pass_d) begin
                        state_q <= ST_PASS;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b1;
                    end else if (verdict_d != FAIL_NONE) begin
                        state_q      <= ST_FAIL;
                        busy_q       <= 1'b0;
                        fail_q       <= 1'b1;
                        fail_code_q  <= verdict_d;
                        fail_index_q <= idx_rd;
                        fail_value_q <= acc_val;
                    end else if (step_ok_d) begin
                        idx_q   <= NE_W'(idx_q + 1'b1);
                        timer_q <= '0;
                    end else begin
                        timer_q <= TMO_W'(timer_q + 1'b1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = busy_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign fail_code  = fail_code_q;
    assign fail_index = fail_index_q;
    assign fail_value = fail_value_q;

endmodule

`default_nettype wire

// File: tb/tb_checkpoint_monitor.sv
// +----------------------------------------------------------------------------+
// | tb_checkpoint_monitor                                                      |
// | Directed and randomized checks of checkpoint_monitor against a sequence    |
// | reference model. Honours CHKMON_SYNC_EN for latency.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_checkpoint_monitor;

    localparam int          N_CHK      = 16;
    localparam int          STABLE_CYC = 2;
    localparam logic [15:0] START      = 16'hA040;
    localparam logic [15:0] PASSC      = 16'hA090;
`ifdef CHKMON_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT  = STABLE_CYC + SYNC;
    localparam int HOLD = LAT + 3;

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] checkbits = '0;
    logic [7:0]  value = '0;
    logic [4:0]  n_expect = '0;
    logic [19:0] tmo_limit = '0;
    logic        exp_wr = 1'b0;
    logic [3:0]  exp_addr = '0;
    logic [7:0]  exp_data = '0;
    logic [7:0]  exp_mask = '0;
    logic        busy, pass, fail;
    logic [2:0]  fail_code;
    logic [3:0]  fail_index;
    logic [7:0]  fail_value;

    checkpoint_monitor dut (
        .clock      (clock),
        .resetb     (resetb),
        .enable     (enable),
        .checkbits  (checkbits),
        .value      (value),
        .n_expect   (n_expect),
        .tmo_limit  (tmo_limit),
        .exp_wr     (exp_wr),
        .exp_addr   (exp_addr),
        .exp_data   (exp_data),
        .exp_mask   (exp_mask),
        .busy       (busy),
        .pass       (pass),
        .fail       (fail),
        .fail_code  (fail_code),
        .fail_index (fail_index),
        .fail_value (fail_value)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  tb_data [N_CHK];
    logic [7:0]  tb_mask [N_CHK];
    logic [15:0] ev_code [$];
    logic [7:0]  ev_val  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic write_tbl(input int a, input logic [7:0] d, input logic [7:0] m, input bit taken);
        @(negedge clock);
        exp_wr = 1'b1; exp_addr = 4'(a); exp_data = d; exp_mask = m;
        @(negedge clock);
        exp_wr = 1'b0;
        if (taken) begin
            tb_data[a] = d;
            tb_mask[a] = m;
        end
    endtask

    task automatic start_run(input int ne, input int tmo);
        @(negedge clock);
        n_expect = 5'(ne); tmo_limit = 20'(tmo);
        checkbits = '0; value = '0;
        enable = 1'b1;
        tick(1);
        check("busy_rise", 32'(busy), 32'(1));
        tick(LAT + 2);
    endtask

    task automatic end_run();
        @(negedge clock);
        enable = 1'b0;
        tick(1);
        check("clr_pass", 32'(pass), 32'(0));
        check("clr_fail", 32'(fail), 32'(0));
        check("clr_busy", 32'(busy), 32'(0));
        check("clr_code", 32'(fail_code), 32'(0));
        tick(2);
    endtask

    task automatic drive_events();
        for (int i = 0; i < ev_code.size(); i++) begin
            checkbits = ev_code[i];
            value     = ev_val[i];
            tick(HOLD);
        end
        tick(LAT + 3);
    endtask

    task automatic build_pass_seq(input int n);
        ev_code.delete(); ev_val.delete();
        ev_code.push_back(START); ev_val.push_back(8'h00);
        for (int i = 0; i < n; i++) begin
            ev_code.push_back(16'(START + 16'(i) + 16'd1));
            ev_val.push_back(tb_data[i]);
        end
        ev_code.push_back(PASSC); ev_val.push_back(8'h00);
    endtask

    // Walk the marker list by the sequencing rules; the bus idles at code 0
    // before the run, so that code counts as already seen.
    task automatic model(input int ne, output bit p, output bit f, output logic [2:0] fc,
                         output logic [3:0] fi, output logic [7:0] fv);
        int          neff;
        int          idx;
        bit          started;
        logic [15:0] prev;
        logic [15:0] c;
        neff = (ne > N_CHK) ? N_CHK : ne;
        idx = 0; started = 0; prev = '0;
        p = 0; f = 0; fc = '0; fi = '0; fv = '0;
        for (int i = 0; i < ev_code.size(); i++) begin
            c = ev_code[i];
            if (c == prev) continue;
            prev = c;
            if (!started) begin
                started = (c == START);
                continue;
            end
            if (c == 16'(START + 16'(idx) + 16'd1) && idx < neff) begin
                if (((ev_val[i] ^ tb_data[idx]) & tb_mask[idx]) != 8'h00) begin
                    f = 1; fc = 3'd1; fi = 4'(idx); fv = ev_val[i];
                    return;
                end
                idx++;
            end else if (c == PASSC) begin
                if (idx == neff) p = 1;
                else begin
                    f = 1; fc = 3'd4; fi = 4'(idx); fv = ev_val[i];
                end
                return;
            end else begin
                f = 1; fc = 3'd2; fi = 4'(idx); fv = ev_val[i];
                return;
            end
        end
    endtask

    task automatic check_run(input int ne);
        bit         p, f;
        logic [2:0] fc;
        logic [3:0] fi;
        logic [7:0] fv;
        model(ne, p, f, fc, fi, fv);
        check("pass", 32'(pass), 32'(p));
        check("fail", 32'(fail), 32'(f));
        check("fail_code", 32'(fail_code), 32'(fc));
        check("busy_done", 32'(busy), 32'(!(p || f)));
        if (f) begin
            check("fail_index", 32'(fail_index), 32'(fi));
            check("fail_value", 32'(fail_value), 32'(fv));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_pass"}, 32'(pass), 32'(0));
        check({tag, "_fail"}, 32'(fail), 32'(0));
        check({tag, "_code"}, 32'(fail_code), 32'(0));
        check({tag, "_idx"},  32'(fail_index), 32'(0));
        check({tag, "_val"},  32'(fail_value), 32'(0));
    endtask

    initial begin
        logic [7:0] plan_tbl [11];
        plan_tbl = '{8'h04, 8'h56, 8'h10, 8'h02, 8'h01, 8'hff, 8'hef, 8'hff, 8'h03, 8'h12, 8'h04};

        tick(2);
        check_all_zero("reset");
        resetb = 1'b1;
        tick(2);

        for (int i = 0; i < N_CHK; i++)
            write_tbl(i, (i < 11) ? plan_tbl[i] : 8'(i * 7), 8'hff, 1'b1);

        // Full passing sequence from the plan.
        start_run(11, 0);
        build_pass_seq(11);
        drive_events();
        check_run(11);
        check("plan_pass", 32'(pass), 32'(1));
        end_run();

        // Value mismatch at A042, then a reset pulse clears the verdict.
        start_run(11, 0);
        build_pass_seq(11);
        ev_val[2] = 8'h57;
        drive_events();
        check_run(11);
        check("mis_code", 32'(fail_code), 32'(1));
        check("mis_idx", 32'(fail_index), 32'(1));
        check("mis_val", 32'(fail_value), 32'(8'h57));
        @(negedge clock);
        resetb = 1'b0;
        #1;
        check_all_zero("rstfail");
        enable = 1'b0;
        tick(1);
        resetb = 1'b1;
        tick(2);

        // Partial mask lets 0x5F through where 0x56 is expected.
        write_tbl(1, 8'h56, 8'hF0, 1'b1);
        start_run(11, 0);
        build_pass_seq(11);
        ev_val[2] = 8'h5F;
        drive_events();
        check_run(11);
        check("mask_pass", 32'(pass), 32'(1));
        end_run();
        write_tbl(1, 8'h56, 8'hff, 1'b1);

        // Skipped checkpoint.
        start_run(11, 0);
        ev_code.delete(); ev_val.delete();
        ev_code.push_back(START);        ev_val.push_back(8'h00);
        ev_code.push_back(16'hA041);     ev_val.push_back(8'h04);
        ev_code.push_back(16'hA043);     ev_val.push_back(8'h02);
        drive_events();
        check_run(11);
        check("seq_code", 32'(fail_code), 32'(2));
        check("seq_idx", 32'(fail_index), 32'(1));
        end_run();

        // Early pass after 5 of 11.
        start_run(11, 0);
        build_pass_seq(5);
        drive_events();
        check_run(11);
        check("early_code", 32'(fail_code), 32'(4));
        check("early_idx", 32'(fail_index), 32'(5));
        end_run();

        // Timeout lands exactly tmo_limit cycles after the A041 acceptance.
        start_run(11, 1000);
        checkbits = START; value = 8'h00;
        tick(HOLD);
        checkbits = 16'hA041; value = 8'h04;
        tick(LAT + 1000);
        check("tmo_early", 32'(fail), 32'(0));
        tick(1);
        check("tmo_fail", 32'(fail), 32'(1));
        check("tmo_code", 32'(fail_code), 32'(3));
        check("tmo_idx", 32'(fail_index), 32'(1));
        end_run();

        // Timeout disabled.
        start_run(11, 0);
        checkbits = START;
        tick(HOLD);
        checkbits = 16'hA041; value = 8'h04;
        tick(2500);
        check("notmo_fail", 32'(fail), 32'(0));
        check("notmo_busy", 32'(busy), 32'(1));
        end_run();

        // One-cycle glitch onto the next expected code is filtered out.
        start_run(11, 0);
        checkbits = START; tick(HOLD);
        checkbits = 16'hA041; value = tb_data[0]; tick(HOLD);
        checkbits = 16'hA042; value = tb_data[1]; tick(1);
        checkbits = 16'hA041; value = tb_data[0]; tick(HOLD);
        for (int i = 1; i < 11; i++) begin
            checkbits = 16'(START + 16'(i) + 16'd1); value = tb_data[i];
            tick(HOLD);
        end
        checkbits = PASSC; tick(LAT + 3);
        check("glitch_pass", 32'(pass), 32'(1));
        check("glitch_fail", 32'(fail), 32'(0));
        end_run();

        // Table write while busy is dropped.
        start_run(11, 0);
        write_tbl(0, 8'h99, 8'hff, 1'b0);
        build_pass_seq(11);
        drive_events();
        check_run(11);
        check("wrbusy_pass", 32'(pass), 32'(1));
        end_run();

        // Reset pulse mid-run.
        start_run(11, 0);
        checkbits = START; tick(HOLD);
        checkbits = 16'hA041; value = tb_data[0]; tick(HOLD);
        check("mid_busy", 32'(busy), 32'(1));
        resetb = 1'b0;
        #1;
        check_all_zero("rstmid");
        enable = 1'b0;
        tick(1);
        resetb = 1'b1;
        tick(2);
        check_all_zero("post_rst");

        // Randomized tables and sequences.
        for (int r = 0; r < 12; r++) begin
            int ne, neff, k;
            for (int i = 0; i < N_CHK; i++)
                write_tbl(i, 8'($urandom), ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'hff, 1'b1);
            ne   = $urandom_range(0, 17);
            neff = (ne > N_CHK) ? N_CHK : ne;
            ev_code.delete(); ev_val.delete();
            ev_code.push_back(START); ev_val.push_back(8'h00);
            for (int i = 0; i < neff + 2; i++) begin
                k = $urandom_range(0, 39);
                if (k < 36) begin
                    ev_code.push_back(16'(START + 16'(i) + 16'd1));
                    if (k < 32 && i < N_CHK) ev_val.push_back(tb_data[i] ^ (8'($urandom) & ~tb_mask[i]));
                    else                     ev_val.push_back(8'($urandom));
                end else if (k < 39) begin
                    ev_code.push_back(16'(START + 16'($urandom_range(1, 16))));
                    ev_val.push_back(8'($urandom));
                end else begin
                    ev_code.push_back(PASSC);
                    ev_val.push_back(8'($urandom));
                end
            end
            ev_code.push_back(PASSC); ev_val.push_back(8'h00);
            start_run(ne, 0);
            drive_events();
            check_run(ne);
            end_run();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
